// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths, the NOP encoding, the default reset PC and the fetch FSM states
package riscv_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
    typedef enum logic {IDLE, RUN} fetch_state_t;
endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: synchronous in-order FIFO with flush, used for the prefetch buffer and the in-flight PC queue
// Ports: clk, rst_n (async active-low); push/din write, pop/dout read head;
//        flush empties the FIFO and wins over push/pop; count, full, empty report occupancy.
module ifetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
            count  <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: owns the PC, issues credit-limited imem fetches, buffers responses and hands instructions to decode
// Ports: clk, rst_n (async active-low); fetch_en gates new requests; redirect_valid/redirect_pc flush and restart;
//        imem_req_* request channel (imem_addr = pc); imem_rsp_* in-order response channel;
//        inst_valid/inst_ready/inst_data/inst_pc decode handshake (NOP and pc 0 when empty).
module ifetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEF,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_en,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t     state, state_n;
    logic [XLEN-1:0]  pc, rsp_pc;
    logic [CW-1:0]    outstanding, outstanding_n, discard, fifo_count;
    logic [CW:0]      inflight;
    logic [2*XLEN-1:0] fifo_dout;
    logic             hs, rsp_ok, push, pop, fifo_empty, pcq_empty;
    logic             fifo_full_unused, pcq_full_unused;

    // every in-flight request owns one PC-queue entry, so its occupancy is the outstanding count;
    // the queue is never flushed so responses to squashed requests still retire their entry
    ifetch_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_pcq (
        .clk(clk), .rst_n(rst_n), .push(hs), .pop(rsp_ok), .flush(1'b0), .din(pc),
        .dout(rsp_pc), .count(outstanding), .full(pcq_full_unused), .empty(pcq_empty)
    );

    ifetch_fifo #(.WIDTH(2*XLEN), .DEPTH(FIFO_DEPTH)) u_buf (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .flush(redirect_valid),
        .din({rsp_pc, imem_rsp_data}), .dout(fifo_dout), .count(fifo_count),
        .full(fifo_full_unused), .empty(fifo_empty)
    );

    // a response with nothing outstanding is a protocol violation and is ignored
    assign rsp_ok        = imem_rsp_valid && !pcq_empty;
    assign hs            = imem_req_valid && imem_req_ready;
    assign outstanding_n = outstanding + CW'(hs) - CW'(rsp_ok);
    assign inflight      = {1'b0, fifo_count} + {1'b0, outstanding};
    assign push          = rsp_ok && discard == '0 && !redirect_valid;
    assign pop           = inst_valid && inst_ready && !redirect_valid;
    assign imem_addr     = pc;
    assign inst_valid    = !fifo_empty;
    assign inst_data     = inst_valid ? fifo_dout[XLEN-1:0] : NOP_INST;
    assign inst_pc       = inst_valid ? fifo_dout[2*XLEN-1:XLEN] : '0;

    // RUN only leaves once no request is stalled, so a presented address is never withdrawn
    always_comb begin
        imem_req_valid = 1'b0;
        state_n        = state;
        imem_req_valid = state == RUN && inflight < (CW+1)'(FIFO_DEPTH);
        state_n        = state == IDLE ? (fetch_en ? RUN : IDLE)
                       : (!fetch_en && !(imem_req_valid && !imem_req_ready)) ? IDLE : RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            discard <= '0;
        end else begin
            state   <= state_n;
            pc      <= redirect_valid ? {redirect_pc[XLEN-1:2], 2'b00} : hs ? pc + 32'd4 : pc;
            discard <= redirect_valid ? outstanding_n
                     : (rsp_ok && discard != '0) ? discard - CW'(1) : discard;
        end
    end
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed scenario bench for ifetch_unit with a fixed-latency in-order memory model
module tb_ifetch_unit;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        fetch_en = 0;
    logic        redirect_valid = 0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready = 0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    int total = 0;
    int bad = 0;
    int lat = 1;
    bit keep_q = 0;
    int mcyc = 0;
    logic [31:0] q_addr[$];
    int q_due[$];

    ifetch_unit dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // memory: acts just after each falling edge, after the tests have driven their inputs
    initial begin
        imem_rsp_valid = 0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            #1;
            mcyc++;
            if (!rst_n && !keep_q) begin
                q_addr.delete();
                q_due.delete();
            end
            imem_rsp_valid = 0;
            imem_rsp_data  = '0;
            if (q_due.size() > 0 && q_due[0] <= mcyc) begin
                imem_rsp_valid = 1;
                imem_rsp_data  = data_of(q_addr[0]);
                void'(q_addr.pop_front());
                void'(q_due.pop_front());
            end
            if (rst_n && imem_req_valid && imem_req_ready) begin
                q_addr.push_back(imem_addr);
                q_due.push_back(mcyc + lat);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic apply_reset;
        @(negedge clk);
        rst_n = 0;
        fetch_en = 0;
        redirect_valid = 0;
        inst_ready = 0;
        imem_req_ready = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid got=%b exp=0", imem_req_valid); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rst_inst_valid got=%b exp=0", inst_valid); end
        total++; if (inst_data !== 32'h13) begin bad++; $display("FAIL rst_inst_data got=%h exp=00000013", inst_data); end
        total++; if (inst_pc !== 32'h0) begin bad++; $display("FAIL rst_inst_pc got=%h exp=0", inst_pc); end
        rst_n = 1;
    endtask

    task automatic test_stream;
        logic [31:0] e;
        apply_reset();
        lat = 1; imem_req_ready = 1; inst_ready = 1; fetch_en = 1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            e = 32'(4 * (k - 1));
            total++; if (imem_req_valid !== 1'b1 || imem_addr !== e) begin bad++; $display("FAIL stream_addr k=%0d got=%b/%h exp=1/%h", k, imem_req_valid, imem_addr, e); end
            e = 32'(4 * (k - 3));
            total++;
            if (k < 3) begin
                if (inst_valid !== 1'b0) begin bad++; $display("FAIL stream_early k=%0d got=%b exp=0", k, inst_valid); end
            end else if (inst_valid !== 1'b1 || inst_pc !== e || inst_data !== data_of(e)) begin
                bad++; $display("FAIL stream_inst k=%0d got=%b/%h/%h exp=1/%h/%h", k, inst_valid, inst_pc, inst_data, e, data_of(e));
            end
        end
    endtask

    task automatic test_backpressure;
        int n = 0;
        apply_reset();
        lat = 1; imem_req_ready = 1; inst_ready = 0; fetch_en = 1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) n++;
        end
        total++; if (n != 4) begin bad++; $display("FAIL bp_count got=%0d exp=4", n); end
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL bp_stall got=%b exp=0", imem_req_valid); end
        total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin bad++; $display("FAIL bp_head got=%b/%h exp=1/0", inst_valid, inst_pc); end
        inst_ready = 1;
        @(negedge clk);
        inst_ready = 0;
        total++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h10) begin bad++; $display("FAIL bp_refill got=%b/%h exp=1/10", imem_req_valid, imem_addr); end
        total++; if (inst_pc !== 32'h4) begin bad++; $display("FAIL bp_next_head got=%h exp=4", inst_pc); end
        @(negedge clk);
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL bp_restall got=%b exp=0", imem_req_valid); end
    endtask

    task automatic test_redirect_inflight;
        apply_reset();
        lat = 3; imem_req_ready = 1; inst_ready = 1; fetch_en = 1;
        repeat (3) @(negedge clk);
        total++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h8) begin bad++; $display("FAIL rdi_pre got=%b/%h exp=1/8", imem_req_valid, imem_addr); end
        imem_req_ready = 0; redirect_valid = 1; redirect_pc = 32'h0000_0102;
        @(negedge clk);
        redirect_valid = 0; imem_req_ready = 1;
        total++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h100) begin bad++; $display("FAIL rdi_addr got=%b/%h exp=1/100", imem_req_valid, imem_addr); end
        for (int k = 4; k <= 7; k++) begin
            total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rdi_drop k=%0d got=%b exp=0", k, inst_valid); end
            @(negedge clk);
        end
        total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst_data !== data_of(32'h100)) begin bad++; $display("FAIL rdi_first got=%b/%h/%h exp=1/100/%h", inst_valid, inst_pc, inst_data, data_of(32'h100)); end
        @(negedge clk);
        total++; if (inst_pc !== 32'h104) begin bad++; $display("FAIL rdi_second got=%h exp=104", inst_pc); end
    endtask

    task automatic test_redirect_collide;
        apply_reset();
        lat = 1; imem_req_ready = 1; inst_ready = 1; fetch_en = 1;
        repeat (3) @(negedge clk);
        total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || imem_rsp_valid !== 1'b1) begin bad++; $display("FAIL col_pre got=%b/%h/%b exp=1/0/1", inst_valid, inst_pc, imem_rsp_valid); end
        redirect_valid = 1; redirect_pc = 32'h0000_0040;
        @(negedge clk);
        redirect_valid = 0;
        total++; if (inst_valid !== 1'b0 || inst_data !== 32'h13 || inst_pc !== 32'h0) begin bad++; $display("FAIL col_flush got=%b/%h/%h exp=0/00000013/0", inst_valid, inst_data, inst_pc); end
        total++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h40) begin bad++; $display("FAIL col_addr got=%b/%h exp=1/40", imem_req_valid, imem_addr); end
        @(negedge clk);
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL col_stale got=%b exp=0", inst_valid); end
        @(negedge clk);
        total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h40) begin bad++; $display("FAIL col_first got=%b/%h exp=1/40", inst_valid, inst_pc); end
    endtask

    task automatic test_wrap;
        logic [31:0] e;
        apply_reset();
        lat = 1; imem_req_ready = 1; inst_ready = 1;
        redirect_valid = 1; redirect_pc = 32'hFFFF_FFFB;
        @(negedge clk);
        redirect_valid = 0; fetch_en = 1;
        total++; if (imem_req_valid !== 1'b0 || imem_addr !== 32'hFFFF_FFF8) begin bad++; $display("FAIL wrap_idle got=%b/%h exp=0/fffffff8", imem_req_valid, imem_addr); end
        for (int k = 2; k <= 6; k++) begin
            @(negedge clk);
            e = 32'hFFFF_FFF8 + 32'(4 * (k - 2));
            if (k <= 4) begin
                total++; if (imem_req_valid !== 1'b1 || imem_addr !== e) begin bad++; $display("FAIL wrap_addr k=%0d got=%b/%h exp=1/%h", k, imem_req_valid, imem_addr, e); end
            end
            e = 32'hFFFF_FFF8 + 32'(4 * (k - 4));
            if (k >= 4) begin
                total++; if (inst_valid !== 1'b1 || inst_pc !== e || inst_data !== data_of(e)) begin bad++; $display("FAIL wrap_inst k=%0d got=%b/%h/%h exp=1/%h/%h", k, inst_valid, inst_pc, inst_data, e, data_of(e)); end
            end
        end
    endtask

    task automatic test_reset_midstream;
        apply_reset();
        lat = 3; imem_req_ready = 1; inst_ready = 0; fetch_en = 1; keep_q = 1;
        repeat (6) @(negedge clk);
        total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || imem_req_valid !== 1'b0) begin bad++; $display("FAIL mid_pre got=%b/%h/%b exp=1/0/0", inst_valid, inst_pc, imem_req_valid); end
        #2;
        rst_n = 0; fetch_en = 0;
        #1;
        total++; if (imem_req_valid !== 1'b0 || imem_addr !== 32'h0) begin bad++; $display("FAIL mid_req got=%b/%h exp=0/0", imem_req_valid, imem_addr); end
        total++; if (inst_valid !== 1'b0 || inst_data !== 32'h13 || inst_pc !== 32'h0) begin bad++; $display("FAIL mid_inst got=%b/%h/%h exp=0/00000013/0", inst_valid, inst_data, inst_pc); end
        @(negedge clk);
        rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin bad++; $display("FAIL mid_late k=%0d got=%b/%b exp=0/0", k, inst_valid, imem_req_valid); end
        end
        keep_q = 0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_collide();
        test_wrap();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
